// File: rtl/tlc_sensor_conditioner.sv
// rtl/tlc_sensor_conditioner.sv - vehicle-detector conditioning for the traffic-light controller
// Two identical channels: synchroniser, debounce, demand latch and sticky stuck-high fault.

module tlc_sensor_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STUCK_CYCLES    = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic green,
    output logic demand,
    output logic stuck
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int SW = $clog2(STUCK_CYCLES) + 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] SCNT_PRE  = SW'(STUCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   deb;
    logic [DW-1:0]          dcnt;
    logic                   lat;
    logic [SW-1:0]          scnt;
    logic                   stuck_q;
    logic                   accept;
    logic                   rise;

    // raw feeds the first flop directly; nothing combinational before it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign accept = (sync != deb) && (dcnt == DCNT_LAST);
    assign rise   = accept && sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (sync == deb) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            deb  <= sync;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // green wins over a simultaneous rise; deb still carries that demand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat <= 1'b0;
        end else if (green) begin
            lat <= 1'b0;
        end else if (rise) begin
            lat <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scnt    <= '0;
            stuck_q <= 1'b0;
        end else if (!deb) begin
            scnt <= '0;
        end else begin
            if (scnt != SCNT_MAX) begin
                scnt <= scnt + 1'b1;
            end
            if (scnt == SCNT_PRE) begin
                stuck_q <= 1'b1;
            end
        end
    end

    // a stuck detector keeps its road served
    assign demand = lat | deb | stuck_q;
    assign stuck  = stuck_q;

endmodule

module tlc_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STUCK_CYCLES    = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    input  logic Ga,
    input  logic Gb,
    output logic Sa,
    output logic Sb,
    output logic stuck_a,
    output logic stuck_b
);

    tlc_sensor_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_a),
        .green (Ga),
        .demand(Sa),
        .stuck (stuck_a)
    );

    tlc_sensor_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_b),
        .green (Gb),
        .demand(Sb),
        .stuck (stuck_b)
    );

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// tb/tb_tlc_sensor_conditioner.sv - directed vectors plus reference model for tlc_sensor_conditioner
// Outputs are compared as {Sa, Sb, stuck_a, stuck_b}.

module tb_tlc_sensor_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic raw_a, raw_b, Ga, Gb;
    logic Sa, Sb, stuck_a, stuck_b;

    int total = 0;
    int bad   = 0;

    tlc_sensor_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .STUCK_CYCLES   (64)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .Ga     (Ga),
        .Gb     (Gb),
        .Sa     (Sa),
        .Sb     (Sb),
        .stuck_a(stuck_a),
        .stuck_b(stuck_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ra;
        bit         rb;
        bit         ga;
        bit         gb;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[17];

    // reference model state, index 0 = road A, 1 = road B
    bit mp0[2], mp1[2], mdeb[2], mlat[2], mstk[2];
    int mrun[2], mhc[2];

    task automatic chk(input string nm, input logic [3:0] exp);
        logic [3:0] act;
        act = {Sa, Sb, stuck_a, stuck_b};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {Sa,Sb,stuck_a,stuck_b}=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            mp0[c] = 0; mp1[c] = 0; mdeb[c] = 0; mlat[c] = 0; mstk[c] = 0;
            mrun[c] = 0; mhc[c] = 0;
        end
    endtask

    task automatic model_step();
        bit r[2];
        bit g[2];
        bit s_old, d_old, rose;
        r[0] = raw_a; r[1] = raw_b; g[0] = Ga; g[1] = Gb;
        for (int c = 0; c < 2; c++) begin
            s_old = mp1[c];
            d_old = mdeb[c];
            rose  = 0;
            if (d_old) begin
                if (mhc[c] < 64) mhc[c]++;
                if (mhc[c] == 64) mstk[c] = 1;
            end else begin
                mhc[c] = 0;
            end
            if (s_old == d_old) begin
                mrun[c] = 0;
            end else if (mrun[c] == 7) begin
                mdeb[c] = s_old;
                mrun[c] = 0;
                rose    = s_old;
            end else begin
                mrun[c]++;
            end
            if (g[c]) mlat[c] = 0;
            else if (rose) mlat[c] = 1;
            mp1[c] = mp0[c];
            mp0[c] = r[c];
        end
    endtask

    function automatic logic [3:0] model_out();
        return {mlat[0] | mdeb[0] | mstk[0], mlat[1] | mdeb[1] | mstk[1], mstk[0], mstk[1]};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int flip_div;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5,  4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  4'b0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  4'b1000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2,  4'b1000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 4'b1000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3,  4'b1000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9,  4'b0000};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  4'b1000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  4'b1000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9,  4'b1000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  4'b0000};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 4'b0100};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 12, 4'b0100};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  4'b0000};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  4'b0000};

        // reset held with detectors active, then release latency
        reset = 1'b0; raw_a = 1'b1; raw_b = 1'b1; Ga = 1'b0; Gb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("reset_hold", 4'b0000);
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("release_latency", (k < 10) ? 4'b0000 : 4'b1100);
        end
        raw_a = 1'b0; raw_b = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("latch_hold", 4'b1100);
        Ga = 1'b1; Gb = 1'b1;
        tick();
        chk("green_clear", 4'b0000);
        Ga = 1'b0; Gb = 1'b0;

        // bounce every 3 cycles must never be accepted
        for (int i = 0; i < 40; i++) begin
            raw_a = ((i / 3) % 2) == 0;
            raw_b = !raw_a;
            tick();
            chk("bounce", 4'b0000);
        end
        raw_a = 1'b0; raw_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("bounce_tail", 4'b0000);
        end

        for (int v = 0; v < 17; v++) begin
            raw_a = tbl[v].ra; raw_b = tbl[v].rb; Ga = tbl[v].ga; Gb = tbl[v].gb;
            for (int k = 0; k < tbl[v].n; k++) tick();
            chk($sformatf("vec%0d", v), tbl[v].exp);
        end
        Ga = 1'b0; Gb = 1'b0; raw_a = 1'b0; raw_b = 1'b0;

        // stuck on road B
        raw_b = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            tick();
            if (k == 10) chk("stuck_deb_rise", 4'b0100);
            if (k == 73) chk("stuck_before", 4'b0100);
            if (k == 74) chk("stuck_set", 4'b0101);
        end
        Gb = 1'b1;
        tick();
        chk("stuck_gb", 4'b0101);
        Gb = 1'b0; raw_b = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("stuck_sticky", 4'b0101);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", 4'b0000);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("after_reset", 4'b0000);

        // randomised run against the reference model
        model_clear();
        flip_div = 6;
        for (int i = 0; i < 5000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: flip_div = 2;
                    1: flip_div = 6;
                    default: flip_div = 20;
                endcase
            end
            if (i % 1000 == 500) begin
                reset = 1'b0;
                model_clear();
                #1;
                chk("rand_reset", model_out());
                tick();
                reset = 1'b1;
            end
            if ($urandom_range(0, flip_div - 1) == 0) raw_a = !raw_a;
            if ($urandom_range(0, flip_div - 1) == 0) raw_b = !raw_b;
            Ga = ($urandom_range(0, 11) == 0);
            Gb = ($urandom_range(0, 11) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("random", model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
